seq_detect_scheduler: RTL and testbench

//  Shares one serial sequence-detector instance between NREQ byte requesters.

---
 rtl/seq_sched_pkg.sv | 17 +
 rtl/seq_detect_scheduler_if.sv | 35 +++
 rtl/rr_arb.sv | 36 +++
 rtl/seq_detect_scheduler.sv | 113 +++++++++++
 tb/tb_seq_detect_scheduler.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the sequence-detector scheduler.
package seq_sched_pkg;

    // Width of one requester byte and of the detector data path.
    localparam int BYTE_W = 8;

    // Eight bit edges for the scan plus one edge for the sticky flag to settle.
    localparam int SCAN_CYCLES_DEF = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Requester-side bundle: request/byte in, grant/done/hit/busy back out.
interface seq_detect_scheduler_if
    import seq_sched_pkg::*;
#(
    parameter int NREQ = 2
);

    logic [NREQ-1:0]        req;
    logic [NREQ*BYTE_W-1:0] data;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic                   hit;
    logic                   busy;

    // Requester population drives req/data and watches the scheduler's answers.
    modport master (
        output req,
        output data,
        input  gnt,
        input  done,
        input  hit,
        input  busy
    );

    // Scheduler side.
    modport slave (
        input  req,
        input  data,
        output gnt,
        output done,
        output hit,
        output busy
    );

endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo NREQ.
// The pointer register itself belongs to the caller.
module rr_arb #(
    parameter  int NREQ  = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Walk from the farthest offset to the nearest so the closest request to ptr wins.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            pos_idx = IDX_W'(pos);
            if (req[pos_idx]) begin
                gnt          = '0;
                gnt[pos_idx] = 1'b1;
                idx          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Shares one serial sequence detector between NREQ byte requesters.
// Grants round-robin, loads the byte with a one-cycle set strobe, waits out the
// MSB-first scan and returns a per-requester done pulse carrying the hit flag.
//
//  state | meaning
//  IDLE  | waiting for any request; winner's byte latched on the way out
//  LOAD  | grant pulse + detector set strobe; rr pointer advances past winner
//  SCAN  | detector shifts the byte; down-counter runs to terminal count 0
//  DONE  | done pulse to the winner with the sampled hit flag
module seq_detect_scheduler
    import seq_sched_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int SCAN_CYCLES = SCAN_CYCLES_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    seq_detect_scheduler_if.slave bus,
    output logic                 det_set_o,
    output logic [BYTE_W-1:0]    det_data_o,
    input  logic                 det_detect_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    sched_state_e     state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [NREQ-1:0]  win_gnt;
    logic [CNT_W-1:0] scan_cnt;

    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  done_q;
    logic             hit_q;
    logic             busy_q;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;

    rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req (bus.req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.hit  = hit_q;
    assign bus.busy = busy_q;

    // Single sequencer: every output is a register so the detector and the
    // requesters never see combinational glitches from the arbiter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            win_idx    <= '0;
            win_gnt    <= '0;
            scan_cnt   <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            hit_q      <= 1'b0;
            busy_q     <= 1'b0;
            det_set_o  <= 1'b0;
            det_data_o <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state      <= ST_LOAD;
                        win_idx    <= arb_idx;
                        win_gnt    <= arb_gnt;
                        gnt_q      <= arb_gnt;
                        det_set_o  <= 1'b1;
                        det_data_o <= bus.data[arb_idx*BYTE_W +: BYTE_W];
                        busy_q     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state     <= ST_SCAN;
                    gnt_q     <= '0;
                    det_set_o <= 1'b0;
                    scan_cnt  <= CNT_W'(SCAN_CYCLES - 1);
                    if (win_idx == IDX_W'(NREQ - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= win_idx + 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (scan_cnt == '0) begin
                        state  <= ST_DONE;
                        hit_q  <= det_detect_i;
                        done_q <= win_gnt;
                    end else begin
                        scan_cnt <= scan_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= '0;
                    hit_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench: scheduler paired with a behavioural 01011 MSB-first detector.
module tb_seq_detect_scheduler;

    logic       clk;
    logic       rst_n;
    logic       det_set;
    logic [7:0] det_data;
    logic       det_detect;

    int n_total = 0;
    int n_pass  = 0;

    seq_detect_scheduler_if #(.NREQ(2)) sif ();

    seq_detect_scheduler #(
        .NREQ        (2),
        .SCAN_CYCLES (9)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .bus          (sif),
        .det_set_o    (det_set),
        .det_data_o   (det_data),
        .det_detect_i (det_detect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector model: set loads the byte and clears the sticky flag, then one
    // bit per edge MSB-first; flag sets once five real bits read 01011.
    logic [7:0] d_sh;
    logic [3:0] d_cnt;
    logic [3:0] d_seen;
    logic [4:0] d_win;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_sh       <= '0;
            d_cnt      <= '0;
            d_seen     <= '0;
            d_win      <= '0;
            det_detect <= 1'b0;
        end else if (det_set) begin
            d_sh       <= det_data;
            d_cnt      <= 4'd8;
            d_seen     <= '0;
            d_win      <= '0;
            det_detect <= 1'b0;
        end else if (d_cnt != 4'd0) begin
            d_win  <= {d_win[3:0], d_sh[7]};
            d_sh   <= {d_sh[6:0], 1'b0};
            d_cnt  <= d_cnt - 4'd1;
            d_seen <= d_seen + 4'd1;
            if (d_seen >= 4'd4 && {d_win[3:0], d_sh[7]} == 5'b01011) begin
                det_detect <= 1'b1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full transaction from an IDLE cycle; returns in the following IDLE cycle.
    task automatic run_one(input string tag, input logic [1:0] req, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [1:0] exp_gnt,
                           input logic [7:0] exp_byte, input logic exp_hit, input bit mess);
        sif.req  = req;
        sif.data = {b1, b0};
        tick;
        chk({tag, ".gnt"},  32'(sif.gnt), 32'(exp_gnt));
        chk({tag, ".set"},  32'(det_set), 32'd1);
        chk({tag, ".byte"}, 32'(det_data), 32'(exp_byte));
        chk({tag, ".busy"}, 32'(sif.busy), 32'd1);
        sif.req = 2'b00;
        for (int c = 2; c <= 10; c++) begin
            tick;
            if (mess) sif.data = 16'h0000;
            chk({tag, ".scan_byte"}, 32'(det_data), 32'(exp_byte));
            chk({tag, ".scan_done"}, 32'(sif.done), 32'd0);
            chk({tag, ".scan_set"},  32'(det_set), 32'd0);
        end
        tick;
        chk({tag, ".done"}, 32'(sif.done), 32'(exp_gnt));
        chk({tag, ".hit"},  32'(sif.hit), 32'(exp_hit));
        tick;
        chk({tag, ".done_clr"}, 32'(sif.done), 32'd0);
        chk({tag, ".hit_clr"},  32'(sif.hit), 32'd0);
        chk({tag, ".idle"},     32'(sif.busy), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        sif.req  = 2'b00;
        sif.data = 16'h0000;

        // Reset held, then released with no requests.
        tick; tick; tick;
        chk("rst.gnt",  32'(sif.gnt), 32'd0);
        chk("rst.done", 32'(sif.done), 32'd0);
        chk("rst.hit",  32'(sif.hit), 32'd0);
        chk("rst.busy", 32'(sif.busy), 32'd0);
        chk("rst.set",  32'(det_set), 32'd0);
        chk("rst.data", 32'(det_data), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("noreq.busy", 32'(sif.busy), 32'd0);
            chk("noreq.gnt",  32'(sif.gnt), 32'd0);
        end

        // Single requester, pattern at the MSB end.
        run_one("t2", 2'b01, 8'h58, 8'h00, 2'b01, 8'h58, 1'b1, 1'b0);
        // Pattern ending on bit 0, then a clean byte after a hit.
        run_one("t3a", 2'b01, 8'h0B, 8'h00, 2'b01, 8'h0B, 1'b1, 1'b0);
        run_one("t3b", 2'b01, 8'h00, 8'h00, 2'b01, 8'h00, 1'b0, 1'b0);
        // Requester 1 alone; pointer sits at 1 and then wraps to 0.
        run_one("t3c", 2'b10, 8'h00, 8'h2B, 2'b10, 8'h2B, 1'b1, 1'b0);

        // Both requesting continuously: alternate grants every 12 cycles.
        sif.data = {8'h2B, 8'hFF};
        sif.req  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("rr.gnt",  32'(sif.gnt), (k % 2 == 1) ? 32'h2 : 32'h1);
            chk("rr.byte", 32'(det_data), (k % 2 == 1) ? 32'h2B : 32'hFF);
            for (int c = 2; c <= 10; c++) begin
                tick;
                chk("rr.scan_gnt", 32'(sif.gnt), 32'd0);
            end
            tick;
            chk("rr.done", 32'(sif.done), (k % 2 == 1) ? 32'h2 : 32'h1);
            chk("rr.hit",  32'(sif.hit), (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr.done_gnt", 32'(sif.gnt), 32'd0);
            tick;
            chk("rr.idle", 32'(sif.busy), 32'd0);
            chk("rr.idle_gnt", 32'(sif.gnt), 32'd0);
        end
        sif.req = 2'b00;

        // Reset pulsed in SCAN after a grant to requester 0 (pointer now 1).
        tick;
        sif.req  = 2'b01;
        sif.data = {8'h00, 8'h58};
        tick;
        chk("mid.gnt", 32'(sif.gnt), 32'd1);
        sif.req = 2'b00;
        tick; tick; tick;
        chk("mid.busy_pre", 32'(sif.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.busy", 32'(sif.busy), 32'd0);
        chk("mid.set",  32'(det_set), 32'd0);
        chk("mid.data", 32'(det_data), 32'd0);
        chk("mid.done", 32'(sif.done), 32'd0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            chk("mid.no_done", 32'(sif.done), 32'd0);
            chk("mid.no_busy", 32'(sif.busy), 32'd0);
        end
        // Pointer back at 0: requester 0 wins over 1.
        run_one("t5", 2'b11, 8'h00, 8'h2B, 2'b01, 8'h00, 1'b0, 1'b0);

        // Data changed during SCAN: result follows the originally granted byte.
        run_one("t6", 2'b01, 8'h58, 8'h00, 2'b01, 8'h58, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
